// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: issues reads, absorbs the 1-cycle read
// latency and re-presents the data as a valid/ready stream through a 2-entry skid buffer.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err_underflow
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
    logic                  err_q, err_d;
    logic [FIFO_WIDTH-1:0] skid_q [2];
    logic                  pop;
    logic [1:0]            level_after_pop;

    always_comb begin
        pop             = (occ_q != 2'd0) && m_ready;
        // Words held or owed once this cycle's pop is taken; a new read only fits below 2.
        level_after_pop = occ_q + {1'b0, inflight_q} - {1'b0, pop};
        fifo_rd_en      = (state_q == RUN) && !fifo_empty && (level_after_pop < 2'd2);

        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = STOP;
            STOP: begin
                if (en)
                    state_d = RUN;
                else if (!inflight_q && (occ_q == 2'd0))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        occ_d      = level_after_pop;
        inflight_d = fifo_rd_en;
        wr_ptr_d   = wr_ptr_q ^ inflight_q;
        rd_ptr_d   = rd_ptr_q ^ pop;
        rd_count_d = rd_count_q + CNT_WIDTH'(pop);
        err_d      = err_q | fifo_underflow;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            rd_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_count_q <= rd_count_d;
            err_q      <= err_d;
        end
    end

    // The read issued last cycle lands in the tail slot this edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (!rst_n)
                skid_q[gi] <= '0;
            else if (inflight_q && (wr_ptr_q == 1'(gi)))
                skid_q[gi] <= fifo_data_out;
        end
    end

    assign m_valid       = (occ_q != 2'd0);
    assign m_data        = skid_q[rd_ptr_q];
    assign busy          = (state_q != IDLE) || (occ_q != 2'd0) || inflight_q;
    assign rd_count      = rd_count_q;
    assign err_underflow = err_q;

    a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, occ_q} + {2'b00, inflight_q}) <= 3'd2);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a behavioural FIFO feeds the reader, a scoreboard
// queue holds the words the consumer must see and a negedge monitor checks them.
module tb_fifo_stream_reader;

    logic        clk, rst_n, en, m_ready;
    logic        fifo_rd_en, fifo_empty, fifo_underflow;
    logic [15:0] fifo_data_out, m_data;
    logic        m_valid, busy, err_underflow;
    logic [15:0] rd_count;

    // Behavioural FIFO: registered read data, combinational empty, registered underflow.
    logic        wr_en, fifo_clr, uf_model, uf_force, fifo_do_rd;
    logic [15:0] wr_data;
    logic [15:0] fmem [16];
    logic [3:0]  fwr, frd;
    logic [4:0]  fcnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q [$];

    fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .fifo_rd_en(fifo_rd_en),
        .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
        .fifo_underflow(fifo_underflow), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .busy(busy), .rd_count(rd_count), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_empty     = (fcnt == 5'd0);
    assign fifo_do_rd     = fifo_rd_en && (fcnt != 5'd0);
    assign fifo_underflow = uf_model | uf_force;

    initial begin
        fwr = 4'd0; frd = 4'd0; fcnt = 5'd0; uf_model = 1'b0; fifo_data_out = 16'h0;
    end

    always @(posedge clk) begin
        if (fifo_clr) begin
            fwr <= 4'd0; frd <= 4'd0; fcnt <= 5'd0; uf_model <= 1'b0;
        end else begin
            if (wr_en) begin
                fmem[fwr] <= wr_data;
                fwr <= fwr + 4'd1;
            end
            if (fifo_do_rd) begin
                fifo_data_out <= fmem[frd];
                frd <= frd + 4'd1;
            end
            fcnt     <= fcnt + 5'(wr_en) - 5'(fifo_do_rd);
            uf_model <= fifo_rd_en && (fcnt == 5'd0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted word must match the scoreboard head; stalled output must hold.
    logic        prev_hold = 1'b0;
    logic [15:0] prev_data = 16'h0;
    always @(negedge clk) begin
        if (rst_n && prev_hold) begin
            chk("hold_m_valid", 32'(m_valid), 32'd1);
            chk("hold_m_data", 32'(m_data), 32'(prev_data));
        end
        if (rst_n && m_valid && m_ready) begin
            if (exp_q.size() == 0)
                chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
            else
                chk("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        prev_hold = rst_n && m_valid && !m_ready;
        prev_data = m_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [15:0] d);
        wr_en = 1'b1; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_reset(input logic clr_fifo);
        en = 1'b0; m_ready = 1'b0; rst_n = 1'b0; fifo_clr = clr_fifo;
        step();
        step();
        rst_n = 1'b1; fifo_clr = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] rd_trace, mv_trace;
        int         nrd;

        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; wr_en = 1'b0; wr_data = 16'h0;
        fifo_clr = 1'b1; uf_force = 1'b0;

        // 1: reset state, with en and m_ready already active
        step();
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_count", 32'(rd_count), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        step();
        rst_n = 1'b1; fifo_clr = 1'b0;

        // 2: full-flow drain of 3 words; reads in sample cycles 1..3, valid in 3..5
        do_reset(1'b1);
        fifo_write(16'h1111); fifo_write(16'h2222); fifo_write(16'h3333);
        exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
        en = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rd_trace[k] = fifo_rd_en;
            mv_trace[k] = m_valid;
        end
        chk("t2_rd_en_trace", 32'(rd_trace), 32'h0E);
        chk("t2_m_valid_trace", 32'(mv_trace), 32'h38);
        wait_drain("t2_drain", 20);
        @(negedge clk);
        chk("t2_rd_count", 32'(rd_count), 32'd3);
        chk("t2_rd_en_idle", 32'(fifo_rd_en), 32'd0);

        // 3: backpressure from the start: exactly two reads, head held, then all 5 in order
        do_reset(1'b1);
        for (int k = 1; k <= 5; k++) begin
            fifo_write(16'(k * 16'h1111));
            exp_q.push_back(16'(k * 16'h1111));
        end
        en = 1'b1; m_ready = 1'b0;
        nrd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            nrd += int'(fifo_rd_en);
        end
        chk("t3_reads_under_bp", 32'(nrd), 32'd2);
        chk("t3_m_valid", 32'(m_valid), 32'd1);
        chk("t3_m_data", 32'(m_data), 32'h1111);
        step();
        m_ready = 1'b1;
        wait_drain("t3_drain", 30);
        step();
        @(negedge clk);
        chk("t3_rd_count", 32'(rd_count), 32'd5);
        chk("t3_fifo_left", 32'(fcnt), 32'd0);

        // 4: enabled on an empty FIFO, then a single late word
        do_reset(1'b1);
        en = 1'b1; m_ready = 1'b1;
        nrd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nrd += int'(fifo_rd_en);
        end
        chk("t4_no_reads_empty", 32'(nrd), 32'd0);
        chk("t4_err_clear", 32'(err_underflow), 32'd0);
        step();
        exp_q.push_back(16'hABCD);
        fifo_write(16'hABCD);
        @(negedge clk);
        chk("t4_rd_en_on_nonempty", 32'(fifo_rd_en), 32'd1);
        @(negedge clk);
        chk("t4_m_valid_lat1", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t4_m_valid_lat2", 32'(m_valid), 32'd1);
        wait_drain("t4_drain", 10);
        chk("t4_err_still_clear", 32'(err_underflow), 32'd0);

        // 5: drop en with occ=1/inflight=1 under backpressure; only those two words come out
        do_reset(1'b1);
        fifo_write(16'h5001); fifo_write(16'h5002); fifo_write(16'h5003); fifo_write(16'h5004);
        exp_q.push_back(16'h5001); exp_q.push_back(16'h5002);
        en = 1'b1; m_ready = 1'b0;
        step(); step(); step();
        en = 1'b0;
        nrd = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nrd += int'(fifo_rd_en);
        end
        chk("t5_no_reads_in_stop", 32'(nrd), 32'd0);
        chk("t5_busy_stop", 32'(busy), 32'd1);
        chk("t5_head", 32'(m_data), 32'h5001);
        step();
        m_ready = 1'b1;
        wait_drain("t5_drain", 20);
        step(); step(); step();
        @(negedge clk);
        chk("t5_busy_idle", 32'(busy), 32'd0);
        chk("t5_fifo_left", 32'(fcnt), 32'd2);
        chk("t5_rd_count", 32'(rd_count), 32'd2);

        // 6: reset with two buffered words; they are lost, the FIFO keeps 6003..6005
        do_reset(1'b1);
        for (int k = 1; k <= 5; k++) fifo_write(16'h6000 + 16'(k));
        en = 1'b1; m_ready = 1'b0;
        repeat (6) step();
        @(negedge clk);
        chk("t6_busy_full", 32'(busy), 32'd1);
        chk("t6_fifo_before", 32'(fcnt), 32'd3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_m_valid", 32'(m_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rd_count", 32'(rd_count), 32'd0);
        exp_q.push_back(16'h6003); exp_q.push_back(16'h6004); exp_q.push_back(16'h6005);
        step();
        m_ready = 1'b1;
        wait_drain("t6_drain", 30);
        step();
        @(negedge clk);
        chk("t6_rd_count_after", 32'(rd_count), 32'd3);

        // 7: underflow flag is sticky until reset
        do_reset(1'b1);
        uf_force = 1'b1;
        step();
        uf_force = 1'b0;
        @(negedge clk);
        chk("t7_err_set", 32'(err_underflow), 32'd1);
        repeat (3) step();
        @(negedge clk);
        chk("t7_err_sticky", 32'(err_underflow), 32'd1);
        do_reset(1'b1);
        @(negedge clk);
        chk("t7_err_cleared", 32'(err_underflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
